// File: rtl/full_adder_pkg.sv
// Shared types and helpers for the registered ripple-carry adder.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic                    co;
        logic [FA_MAX_WIDTH-1:0] s;
    } fa_res_t;

    // Bits of s above 'width' are cleared so results of narrower adders compare cleanly.
    function automatic fa_res_t fa_res_make(input int width, input logic co,
                                            input logic [FA_MAX_WIDTH-1:0] s);
        fa_res_t                 res;
        logic [FA_MAX_WIDTH-1:0] mask;
        if (width >= FA_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (FA_MAX_WIDTH'(1) << width) - FA_MAX_WIDTH'(1);
        end
        res.co = co;
        res.s  = s & mask;
        return res;
    endfunction

    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; master drives operands, slave is the adder.
// With FULL_ADDER_OVF_EN defined the bundle also carries ovf.
interface full_adder_if #(parameter int WIDTH = 1) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, c,
        input  s, co, out_valid
`ifdef FULL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, c,
        output s, co, out_valid
`ifdef FULL_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/full_adder_fa_bit.sv
// Combinational single-bit full adder cell used as one stage of the ripple chain.
module fa_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign {cout, sum} = fa_cell(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with a one-cycle registered result and valid flag.
// FULL_ADDER_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    full_adder_if.slave bus
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_bit u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (w_carry[i]),
            .sum  (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_valid;

    // Result flops only load on a valid beat, so X operands while idle never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_co    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s  <= w_sum;
                r_co <= w_carry[WIDTH];
            end
        end
    end

    assign bus.s         = r_s;
    assign bus.co        = r_co;
    assign bus.out_valid = r_valid;

`ifdef FULL_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomised self-check of full_adder at WIDTH 1, 8 and 33 side by side.
module tb_full_adder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    full_adder_if #(.WIDTH(1))  bus1 ();
    full_adder_if #(.WIDTH(8))  bus8 ();
    full_adder_if #(.WIDTH(33)) bus33 ();

    full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    full_adder #(.WIDTH(33)) dut33 (.clk(clk), .rst(rst), .bus(bus33));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results as plain integers {co, s}, plus valid and signed overflow.
    logic [64:0] m1, m8, m33;
    logic        mv;
    logic        mo1, mo8, mo33;

    function automatic logic ovfOf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [63:0] a,
                                 input logic [63:0] b, input logic c);
        logic [0:0]  a1, b1;
        logic [7:0]  a8, b8;
        logic [32:0] a33, b33;
        a1  = a[0:0];  b1  = b[0:0];
        a8  = a[7:0];  b8  = b[7:0];
        a33 = a[32:0]; b33 = b[32:0];
        rst = r;
        bus1.in_valid  = v; bus1.a  = a1;  bus1.b  = b1;  bus1.c  = c;
        bus8.in_valid  = v; bus8.a  = a8;  bus8.b  = b8;  bus8.c  = c;
        bus33.in_valid = v; bus33.a = a33; bus33.b = b33; bus33.c = c;
        @(posedge clk);
        #1;
        if (r) begin
            m1 = '0; m8 = '0; m33 = '0; mo1 = 0; mo8 = 0; mo33 = 0; mv = 0;
        end else begin
            mv = v;
            if (v) begin
                m1   = 65'(a1) + 65'(b1) + 65'(c);
                m8   = 65'(a8) + 65'(b8) + 65'(c);
                m33  = 65'(a33) + 65'(b33) + 65'(c);
                mo1  = ovfOf(a1[0], b1[0], m1[0]);
                mo8  = ovfOf(a8[7], b8[7], m8[7]);
                mo33 = ovfOf(a33[32], b33[32], m33[32]);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "/s1"},  65'(bus1.s),  65'(m1[0:0]));
        checkOutput({tag, "/co1"}, 65'(bus1.co), 65'(m1[1]));
        checkOutput({tag, "/s8"},  65'(bus8.s),  65'(m8[7:0]));
        checkOutput({tag, "/co8"}, 65'(bus8.co), 65'(m8[8]));
        checkOutput({tag, "/s33"}, 65'(bus33.s), 65'(m33[32:0]));
        checkOutput({tag, "/co33"}, 65'(bus33.co), 65'(m33[33]));
        checkOutput({tag, "/v1"},  65'(bus1.out_valid),  65'(mv));
        checkOutput({tag, "/v8"},  65'(bus8.out_valid),  65'(mv));
        checkOutput({tag, "/v33"}, 65'(bus33.out_valid), 65'(mv));
`ifdef FULL_ADDER_OVF_EN
        checkOutput({tag, "/ovf1"},  65'(bus1.ovf),  65'(mo1));
        checkOutput({tag, "/ovf8"},  65'(bus8.ovf),  65'(mo8));
        checkOutput({tag, "/ovf33"}, 65'(bus33.ovf), 65'(mo33));
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m1 = '0; m8 = '0; m33 = '0; mv = 0; mo1 = 0; mo8 = 0; mo33 = 0;

        // Reset with unknown operands
        applyStimulus(1'b1, 1'b1, 'x, 'x, 1'bx);
        applyStimulus(1'b1, 1'b1, 'x, 'x, 1'bx);
        checkOutput("rst_s1", 65'(bus1.s), 65'd0);
        checkOutput("rst_co1", 65'(bus1.co), 65'd0);
        checkOutput("rst_v1", 65'(bus1.out_valid), 65'd0);
        checkOutput("rst_s8", 65'(bus8.s), 65'd0);
        checkOutput("rst_v33", 65'(bus33.out_valid), 65'd0);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("rst_ovf8", 65'(bus8.ovf), 65'd0);
`endif

        // WIDTH=1 truth table, one vector per cycle
        applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 1'b1);
        checkOutput("tt001_s", 65'(bus1.s), 65'd1);
        checkOutput("tt001_co", 65'(bus1.co), 65'd0);
        checkOutput("tt001_v", 65'(bus1.out_valid), 65'd1);
        applyStimulus(1'b0, 1'b1, 64'd0, 64'd1, 1'b1);
        checkOutput("tt011_s", 65'(bus1.s), 65'd0);
        checkOutput("tt011_co", 65'(bus1.co), 65'd1);
        applyStimulus(1'b0, 1'b1, 64'd1, 64'd1, 1'b1);
        checkOutput("tt111_s", 65'(bus1.s), 65'd1);
        checkOutput("tt111_co", 65'(bus1.co), 65'd1);
        applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 1'b0);
        checkOutput("tt000_s", 65'(bus1.s), 65'd0);
        checkOutput("tt000_co", 65'(bus1.co), 65'd0);
        checkModel("tt");

        // WIDTH=8 and WIDTH=33 carry boundaries
        applyStimulus(1'b0, 1'b1, 64'hFF, 64'h01, 1'b0);
        checkOutput("w8_ff01_s", 65'(bus8.s), 65'h00);
        checkOutput("w8_ff01_co", 65'(bus8.co), 65'd1);
        applyStimulus(1'b0, 1'b1, 64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF, 1'b1);
        checkOutput("w8_max_s", 65'(bus8.s), 65'hFF);
        checkOutput("w8_max_co", 65'(bus8.co), 65'd1);
        checkOutput("w33_max_s", 65'(bus33.s), 65'h1_FFFF_FFFF);
        checkOutput("w33_max_co", 65'(bus33.co), 65'd1);
        checkModel("max");

        // Valid gating: result holds while idle, even with X operands
        applyStimulus(1'b0, 1'b1, 64'h35, 64'h4A, 1'b1);
        checkOutput("gate_load_s8", 65'(bus8.s), 65'h80);
        applyStimulus(1'b0, 1'b0, 64'h11, 64'h22, 1'b1);
        applyStimulus(1'b0, 1'b0, 'x, 'x, 1'bx);
        applyStimulus(1'b0, 1'b0, 64'hFFFF, 64'h1234, 1'b0);
        checkOutput("gate_hold_s8", 65'(bus8.s), 65'h80);
        checkOutput("gate_hold_co8", 65'(bus8.co), 65'd0);
        checkOutput("gate_hold_v8", 65'(bus8.out_valid), 65'd0);
        checkModel("gate");

        // Reset wins over a simultaneous valid beat
        applyStimulus(1'b0, 1'b1, 64'hFF, 64'hFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h11, 64'h22, 1'b0);
        checkOutput("midrst_s8", 65'(bus8.s), 65'd0);
        checkOutput("midrst_co8", 65'(bus8.co), 65'd0);
        checkOutput("midrst_v8", 65'(bus8.out_valid), 65'd0);
        checkModel("midrst");

`ifdef FULL_ADDER_OVF_EN
        applyStimulus(1'b0, 1'b1, 64'h7F, 64'h01, 1'b0);
        checkOutput("ovf_pos_s8", 65'(bus8.s), 65'h80);
        checkOutput("ovf_pos_ovf8", 65'(bus8.ovf), 65'd1);
        applyStimulus(1'b0, 1'b1, 64'h80, 64'hFF, 1'b0);
        checkOutput("ovf_neg_ovf8", 65'(bus8.ovf), 65'd1);
        checkOutput("ovf_neg_co8", 65'(bus8.co), 65'd1);
        checkModel("ovf");
`endif

        // Randomised operands with occasional idle cycles
        for (int i = 0; i < 10000; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            applyStimulus(1'b0, ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)));
            checkModel("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
